// File: rtl/pipeline_stage4_mem_if.sv
// Data-memory bus between the MEM stage (master) and a single-port data memory (slave).
// A request is held stable until dmem_ready completes it or the stage aborts it.
interface pipeline_stage4_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/pipeline_stage4_mem.sv
// RV32I memory stage: drives the data memory, formats load/store data, registers MEM/WB.
// Optional MEM_MISALIGN_EN: misaligned half/word accesses are suppressed and reported.
module pipeline_stage4_mem #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic [1:0]  Result,
  input  logic [4:0]  RdD,
  input  logic [31:0] pc_incr4_out,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] wdata,
  input  logic [1:0]  acc_type,
  input  logic        u,
  input  logic [6:0]  op,
  pipeline_stage4_mem_if.master dmem,
  output logic        stall_o,
  output logic        timeout_o,
  output logic        RegWrite_o,
  output logic [1:0]  Result_o,
  output logic [4:0]  RdD_o,
  output logic [31:0] pc_incr4_out_o,
  output logic [31:0] ALU_Result_o,
  output logic [6:0]  op_out,
  output logic [31:0] ReadData_o,
`ifdef MEM_MISALIGN_EN
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
`endif
  output logic        dbg_state_o
);
  // Handshake: dmem_req stays high with stable address/data until a cycle where
  // dmem_ready is high (completion) or the watchdog aborts the access.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        regwrite_q, regwrite_d;
  logic [1:0]  result_q, result_d;
  logic [4:0]  rdd_q, rdd_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] alu_q, alu_d;
  logic [6:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  logic [1:0]  lane;
  logic        is_load, misaligned, access, req, complete, abort;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  assign lane    = ALU_Result[1:0];
  assign is_load = (Result == 2'b01);

`ifdef MEM_MISALIGN_EN
  logic        mis_q, mis_d;
  logic [31:0] mis_addr_q, mis_addr_d;
  assign misaligned = (MemWrite | is_load) &
                      (((acc_type == 2'b01) & lane[0]) | (acc_type[1] & (lane != 2'b00)));
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
`else
  assign misaligned = 1'b0;
`endif

  assign access = (MemWrite | is_load) & ~misaligned;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    if (state_q == IDLE) begin
      if (access) begin
        req = 1'b1;
        if (dmem.dmem_ready) begin
          complete = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
    end else begin
      req = 1'b1;
      if (dmem.dmem_ready) begin
        complete = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end else if (cnt_q == MAX_W) begin
        // watchdog expiry counts as completion so the pipeline can move on
        abort    = 1'b1;
        complete = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign stall_o       = access & ~complete & ~rst;
  assign dmem.dmem_req = req & ~rst;
  assign dmem.dmem_we  = MemWrite;
  assign dmem.dmem_addr = {ALU_Result[31:2], 2'b00};

  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = wdata;
    if (MemWrite) begin
      case (acc_type)
        2'b00: begin
          dmem.dmem_be    = 4'b0001 << lane;
          dmem.dmem_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          dmem.dmem_be    = 4'b0011 << {lane[1], 1'b0};
          dmem.dmem_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign sel_byte = dmem.dmem_rdata[{lane, 3'b000} +: 8];
  assign sel_half = dmem.dmem_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (acc_type)
      2'b00:   load_ext = {{24{~u & sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = {{16{~u & sel_half[15]}}, sel_half};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  // MEM/WB: a bubble enters while stalled; aborted or misaligned loads never write back
  always_comb begin
    regwrite_d = RegWrite & ~abort & ~(misaligned & is_load);
    result_d   = Result;
    rdd_d      = RdD;
    if (stall_o) begin
      regwrite_d = 1'b0;
      result_d   = 2'b00;
      rdd_d      = 5'd0;
    end
    pc4_d     = pc_incr4_out;
    alu_d     = ALU_Result;
    op_d      = op;
    rdata_d   = (complete & ~abort & is_load) ? load_ext : rdata_q;
    timeout_d = abort;
  end

`ifdef MEM_MISALIGN_EN
  always_comb begin
    mis_d      = misaligned;
    mis_addr_d = misaligned ? ALU_Result : mis_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      result_q   <= '0;
      rdd_q      <= '0;
      pc4_q      <= '0;
      alu_q      <= '0;
      op_q       <= '0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      result_q   <= result_d;
      rdd_q      <= rdd_d;
      pc4_q      <= pc4_d;
      alu_q      <= alu_d;
      op_q       <= op_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
    end
  end

  assign RegWrite_o     = regwrite_q;
  assign Result_o       = result_q;
  assign RdD_o          = rdd_q;
  assign pc_incr4_out_o = pc4_q;
  assign ALU_Result_o   = alu_q;
  assign op_out         = op_q;
  assign ReadData_o     = rdata_q;
  assign timeout_o      = timeout_q;
  assign dbg_state_o    = (state_q == WAIT);
endmodule

// File: tb/tb_pipeline_stage4_mem.sv
// Scoreboarded bench for pipeline_stage4_mem: directed cases plus random instructions
// against a plain-arithmetic model of load/store formatting and wait/abort timing.
`timescale 1ns/1ps
module tb_pipeline_stage4_mem;
  localparam int MAX_WAIT = 4;
  localparam int NEVER    = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemWrite, u;
  logic [1:0]  Result, acc_type;
  logic [4:0]  RdD;
  logic [31:0] pc_incr4_out, ALU_Result, wdata;
  logic [6:0]  op;
  logic        stall_o, timeout_o, RegWrite_o, dbg_state_o;
  logic [1:0]  Result_o;
  logic [4:0]  RdD_o;
  logic [31:0] pc_incr4_out_o, ALU_Result_o, ReadData_o;
  logic [6:0]  op_out;
`ifdef MEM_MISALIGN_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  pipeline_stage4_mem_if dmem_bus ();

  pipeline_stage4_mem #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemWrite(MemWrite), .Result(Result),
    .RdD(RdD), .pc_incr4_out(pc_incr4_out), .ALU_Result(ALU_Result), .wdata(wdata),
    .acc_type(acc_type), .u(u), .op(op), .dmem(dmem_bus.master), .stall_o(stall_o),
    .timeout_o(timeout_o), .RegWrite_o(RegWrite_o), .Result_o(Result_o), .RdD_o(RdD_o),
    .pc_incr4_out_o(pc_incr4_out_o), .ALU_Result_o(ALU_Result_o), .op_out(op_out),
    .ReadData_o(ReadData_o),
`ifdef MEM_MISALIGN_EN
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  res;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [6:0]  op;
    logic        tmo;
    logic [7:0]  stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          draining = 1'b0;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] w, int lane, logic [1:0] ty, logic uu);
    int unsigned v;
    case (ty)
      2'b00: begin
        v = (w >> (8 * lane)) & 32'hFF;
        if (!uu && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (w >> (16 * (lane / 2))) & 32'hFFFF;
        if (!uu && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_be(logic mw, int lane, logic [1:0] ty);
    if (!mw) return 32'hF;
    case (ty)
      2'b00:   return 32'(1 << lane);
      2'b01:   return 32'(3 << (lane & 2));
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(logic [31:0] w, logic [1:0] ty);
    case (ty)
      2'b00:   return (w & 32'hFF) * 32'h0101_0101;
      2'b01:   return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic set_nop();
    RegWrite = 1'b0; MemWrite = 1'b0; Result = 2'b00; RdD = '0; acc_type = '0; u = 1'b0;
    pc_incr4_out = '0; ALU_Result = '0; wdata = '0; op = '0;
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rdata = '0;
  endtask

  // Issues one instruction; the memory answers after lat cycles (never if lat > MAX_WAIT).
  task automatic run_instr(input logic rw, input logic mw, input logic [1:0] res,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [1:0] ty, input logic uu, input logic [31:0] rword,
                           input int lat);
    bit          acc  = mw || (res == 2'b01);
    bit          ld   = (res == 2'b01);
    bit          tmo  = acc && (lat > MAX_WAIT);
    int          nst  = !acc ? 0 : (lat > MAX_WAIT ? MAX_WAIT : lat);
    logic [31:0] pc4  = $urandom;
    logic [6:0]  opc  = 7'($urandom);
    bit          done = 1'b0;
    exp_t        e;
    if (ld && !tmo) model_rdata = model_load(rword, int'(alu[1:0]), ty, uu);
    e.rw = rw && !tmo; e.res = res; e.rd = rd; e.pc4 = pc4; e.alu = alu;
    e.rdata = model_rdata; e.op = opc; e.tmo = tmo; e.stalls = 8'(nst);
    exp_q.push_back(e);
    RegWrite = rw; MemWrite = mw; Result = res; RdD = rd; pc_incr4_out = pc4;
    ALU_Result = alu; wdata = wd; acc_type = ty; u = uu; op = opc;
    for (int c = 0; c < 40; c++) begin
      dmem_bus.dmem_ready = acc ? (c == lat) : 1'($urandom_range(0, 1));
      dmem_bus.dmem_rdata = (acc && c == lat) ? rword : $urandom;
      @(negedge clk);
      chk("dmem_req", 32'(dmem_bus.dmem_req), 32'(acc));
      if (acc) begin
        chk("dmem_addr", dmem_bus.dmem_addr, {alu[31:2], 2'b00});
        chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(mw));
        chk("dmem_be", 32'(dmem_bus.dmem_be), model_be(mw, int'(alu[1:0]), ty));
        if (mw) chk("dmem_wdata", dmem_bus.dmem_wdata, model_wd(wd, ty));
      end
      done = !stall_o;
      @(posedge clk); #1;
      if (done) break;
    end
    if (!done) chk("instr_bound", 32'd0, 32'd1);
    dmem_bus.dmem_ready = 1'b0;
  endtask

  // Monitor: every non-stalled cycle retires one instruction into MEM/WB on the next edge.
  initial begin
    int   stall_run   = 0;
    int   done_stalls = 0;
    bit   have_prev   = 1'b0;
    bit   prev_stall  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
        stall_run = 0;
        continue;
      end
      if (have_prev) begin
        if (prev_stall) begin
          chk("bubble_regwrite", 32'(RegWrite_o), 32'd0);
          chk("bubble_result", 32'(Result_o), 32'd0);
          chk("bubble_rd", 32'(RdD_o), 32'd0);
          chk("bubble_timeout", 32'(timeout_o), 32'd0);
        end else if (exp_q.size() == 0) begin
          if (!draining) chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("RegWrite_o", 32'(RegWrite_o), 32'(e.rw));
          chk("Result_o", 32'(Result_o), 32'(e.res));
          chk("RdD_o", 32'(RdD_o), 32'(e.rd));
          chk("pc_incr4_out_o", pc_incr4_out_o, e.pc4);
          chk("ALU_Result_o", ALU_Result_o, e.alu);
          chk("op_out", 32'(op_out), 32'(e.op));
          chk("ReadData_o", ReadData_o, e.rdata);
          chk("timeout_o", 32'(timeout_o), 32'(e.tmo));
          chk("stall_cycles", 32'(done_stalls), 32'(e.stalls));
        end
      end
      if (stall_o) stall_run++;
      else begin
        done_stalls = stall_run;
        stall_run   = 0;
      end
      prev_stall = stall_o;
      have_prev  = 1'b1;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_dmem_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
    chk("rst_result", 32'(Result_o), 32'd0);
    chk("rst_rd", 32'(RdD_o), 32'd0);
    chk("rst_pc4", pc_incr4_out_o, 32'd0);
    chk("rst_alu", ALU_Result_o, 32'd0);
    chk("rst_op", 32'(op_out), 32'd0);
    chk("rst_readdata", ReadData_o, 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0]  ty, res;
    logic [31:0] alu;
    logic        mw;
    int          kind;
    set_nop();
    rst = 1'b1;
    MemWrite = 1'b1; ALU_Result = 32'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // SW, LB signed/unsigned, LH with 3 wait cycles, SB, watchdog abort
    run_instr(1'b0, 1'b1, 2'b00, 5'd0, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 0);
    run_instr(1'b1, 1'b0, 2'b01, 5'd5, 32'h103, 32'h0, 2'b00, 1'b0, 32'h80AA5500, 0);
    run_instr(1'b1, 1'b0, 2'b01, 5'd6, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80AA5500, 0);
    run_instr(1'b1, 1'b0, 2'b01, 5'd7, 32'h102, 32'h0, 2'b01, 1'b0, 32'h80011234, 3);
    run_instr(1'b0, 1'b1, 2'b00, 5'd0, 32'h101, 32'h000000AB, 2'b00, 1'b0, 32'h0, 0);
    run_instr(1'b1, 1'b0, 2'b01, 5'd9, 32'h200, 32'h0, 2'b10, 1'b0, 32'h12345678, NEVER);
    run_instr(1'b1, 1'b0, 2'b00, 5'd3, 32'h55, 32'h0, 2'b10, 1'b0, 32'h0, 0);

    // Reset while waiting abandons the access
    RegWrite = 1'b1; MemWrite = 1'b0; Result = 2'b01; RdD = 5'd4; ALU_Result = 32'h300;
    acc_type = 2'b10; dmem_bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("midwait_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs();
    model_rdata = '0;
    @(posedge clk); #1;
    set_nop();
    rst = 1'b0;

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      ty   = 2'($urandom_range(0, 3));
      alu  = $urandom;
`ifdef MEM_MISALIGN_EN
      if (ty == 2'b01) alu[0] = 1'b0;
      if (ty[1]) alu[1:0] = 2'b00;
`endif
      mw  = (kind == 2);
      res = (kind == 1 || kind == 3) ? 2'b01 : (kind == 2 ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00));
      run_instr(1'($urandom_range(0, 1)), mw, res, 5'($urandom), alu, $urandom, ty,
                1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 6));
    end

    set_nop();
    draining = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
